hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage CPU. It detects load-use hazards, applies branch flushes, and freezes the pipeline while a data-memory access waits on `dm_ready`. It drives hold/bubble/flush controls into the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers, and keeps a saturating stall-cycle counter. It sits beside the forwarding unit and observes the ID, EXE and MEM stage control signals.

---
 rtl/hazard_ctrl.sv | 75 +++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush and DM-wait pipeline sequencing with a saturating stall counter
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_reg1_addr,
  input  logic [REG_AW-1:0] id_reg2_addr,
  input  logic [REG_AW-1:0] id_sw_addr,
  input  logic              id_reg1_read,
  input  logic              id_reg2_read,
  input  logic              id_sw_read,
  input  logic [REG_AW-1:0] exe_write_addr,
  input  logic              exe_reg_write,
  input  logic              exe_DM_read,
  input  logic              branch_true,
  input  logic              mem_DM_read,
  input  logic              mem_DM_write,
  input  logic              dm_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_exe_flush,
  output logic              id_exe_bubble,
  output logic              id_exe_stall,
  output logic              exe_mem_stall,
  output logic              mem_wb_bubble,
  output logic              dm_err,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic mem_acc, freeze, lu;
  assign mem_acc = mem_DM_read | mem_DM_write;
  assign freeze  = (state == S_ERR) | (mem_acc & ~dm_ready);
  // register 0 deliberately not excluded from the hazard match
  assign lu = exe_DM_read & exe_reg_write &
              ((id_reg1_read & (id_reg1_addr == exe_write_addr)) |
               (id_reg2_read & (id_reg2_addr == exe_write_addr)) |
               (id_sw_read   & (id_sw_addr   == exe_write_addr)));
  assign pc_stall      = freeze | (~branch_true & lu);
  assign if_id_stall   = pc_stall;
  assign id_exe_bubble = ~freeze & ~branch_true & lu;
  assign if_id_flush   = ~freeze & branch_true;
  assign id_exe_flush  = if_id_flush;
  assign id_exe_stall  = freeze;
  assign exe_mem_stall = freeze;
  assign mem_wb_bubble = freeze;
  assign dm_err        = state == S_ERR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        S_RUN: if (mem_acc && !dm_ready) begin
          state    <= S_WAIT;
          wait_cnt <= WW'(1);
        end
        S_WAIT: if (dm_ready) begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WW'(WAIT_MAX)) state <= S_ERR;
        else wait_cnt <= wait_cnt + WW'(1);
        default: state <= S_ERR;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl at default widths plus a 4-bit counter instance
module tb_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic [4:0] id_reg1_addr, id_reg2_addr, id_sw_addr, exe_write_addr;
  logic id_reg1_read, id_reg2_read, id_sw_read, exe_reg_write, exe_DM_read;
  logic branch_true, mem_DM_read, mem_DM_write, dm_ready;
  logic pc_stall, if_id_stall, if_id_flush, id_exe_flush, id_exe_bubble;
  logic id_exe_stall, exe_mem_stall, mem_wb_bubble, dm_err;
  logic [15:0] stall_cnt;
  logic pc_stall4, if_id_stall4, if_id_flush4, id_exe_flush4, id_exe_bubble4;
  logic id_exe_stall4, exe_mem_stall4, mem_wb_bubble4, dm_err4;
  logic [3:0] stall_cnt4;
  int checks = 0, failures = 0;
  localparam logic [7:0] NONE = 8'b0000_0000, LU = 8'b1100_1000,
                         BR = 8'b0011_0000, FRZ = 8'b1100_0111;
  wire [7:0] ctrl = {pc_stall, if_id_stall, if_id_flush, id_exe_flush,
                     id_exe_bubble, id_exe_stall, exe_mem_stall, mem_wb_bubble};

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_sw_addr(id_sw_addr), .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_sw_read(id_sw_read), .exe_write_addr(exe_write_addr), .exe_reg_write(exe_reg_write),
    .exe_DM_read(exe_DM_read), .branch_true(branch_true), .mem_DM_read(mem_DM_read),
    .mem_DM_write(mem_DM_write), .dm_ready(dm_ready), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .id_exe_bubble(id_exe_bubble), .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .dm_err(dm_err), .stall_cnt(stall_cnt));

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_sw_addr(id_sw_addr), .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_sw_read(id_sw_read), .exe_write_addr(exe_write_addr), .exe_reg_write(exe_reg_write),
    .exe_DM_read(exe_DM_read), .branch_true(branch_true), .mem_DM_read(mem_DM_read),
    .mem_DM_write(mem_DM_write), .dm_ready(dm_ready), .pc_stall(pc_stall4),
    .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4), .id_exe_flush(id_exe_flush4),
    .id_exe_bubble(id_exe_bubble4), .id_exe_stall(id_exe_stall4), .exe_mem_stall(exe_mem_stall4),
    .mem_wb_bubble(mem_wb_bubble4), .dm_err(dm_err4), .stall_cnt(stall_cnt4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_reg1_addr, id_reg2_addr, id_sw_addr, exe_write_addr} = '0;
    {id_reg1_read, id_reg2_read, id_sw_read, exe_reg_write, exe_DM_read} = '0;
    {branch_true, mem_DM_read, mem_DM_write} = '0;
    dm_ready = 1;
  endtask

  initial begin
    idle();
    tick(); tick();
    chk("reset_ctrl", 32'(ctrl), 32'(NONE));
    chk("reset_cnt", 32'(stall_cnt), 0);
    chk("reset_err", 32'(dm_err), 0);
    rst = 1;
    tick();
    // load-use via reg2
    exe_write_addr = 3; exe_reg_write = 1; exe_DM_read = 1;
    id_reg2_addr = 3; id_reg2_read = 1;
    #1 chk("lu_reg2", 32'(ctrl), 32'(LU));
    tick();
    chk("lu_cnt", 32'(stall_cnt), 1);
    exe_DM_read = 0; mem_DM_read = 1;
    #1 chk("lu_release", 32'(ctrl), 32'(NONE));
    tick();
    chk("lu_cnt_hold", 32'(stall_cnt), 1);
    idle();
    // store source
    exe_write_addr = 5; exe_reg_write = 1; exe_DM_read = 1;
    id_sw_addr = 5; id_sw_read = 1;
    #1 chk("lu_sw", 32'(ctrl), 32'(LU));
    tick();
    chk("sw_cnt", 32'(stall_cnt), 2);
    id_sw_read = 0;
    #1 chk("sw_noread", 32'(ctrl), 32'(NONE));
    id_reg1_addr = 5; id_reg1_read = 1; exe_reg_write = 0;
    #1 chk("lu_nowrite", 32'(ctrl), 32'(NONE));
    // branch wins over load-use
    exe_reg_write = 1; branch_true = 1;
    #1 chk("br_lu", 32'(ctrl), 32'(BR));
    tick();
    chk("br_cnt", 32'(stall_cnt), 2);
    idle();
    // 3-cycle DM wait
    mem_DM_read = 1; dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("wait_frz%0d", i), 32'(ctrl), 32'(FRZ));
      tick();
    end
    dm_ready = 1;
    #1 chk("wait_release", 32'(ctrl), 32'(NONE));
    tick();
    chk("wait_cnt", 32'(stall_cnt), 5);
    idle();
    #1 chk("wait_run", 32'(ctrl), 32'(NONE));
    // freeze over branch, then flush on release
    branch_true = 1; mem_DM_write = 1; dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("frzbr%0d", i), 32'(ctrl), 32'(FRZ));
      tick();
    end
    dm_ready = 1;
    #1 chk("frzbr_release", 32'(ctrl), 32'(BR));
    tick();
    chk("frzbr_cnt", 32'(stall_cnt), 8);
    chk("frzbr_cnt4", 32'(stall_cnt4), 8);
    idle();
    // timeout after WAIT_MAX+1 low cycles
    mem_DM_read = 1; dm_ready = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_err_15", 32'(dm_err), 0);
    tick();
    chk("to_err_16", 32'(dm_err), 1);
    idle();
    #1 chk("err_frz", 32'(ctrl), 32'(FRZ));
    tick(); tick();
    chk("err_sticky", 32'(dm_err), 1);
    chk("err_frz2", 32'(ctrl), 32'(FRZ));
    chk("err_cnt", 32'(stall_cnt), 26);
    chk("sat_cnt4", 32'(stall_cnt4), 15);
    tick();
    chk("sat_hold4", 32'(stall_cnt4), 15);
    // asynchronous reset out of ERR
    rst = 0;
    #1 chk("rst_err", 32'(dm_err), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_ctrl", 32'(ctrl), 32'(NONE));
    tick();
    rst = 1;
    tick();
    chk("post_rst_ctrl", 32'(ctrl), 32'(NONE));
    // reset mid-WAIT clears wait_cnt: timeout needs a full 16 cycles again
    mem_DM_read = 1; dm_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    idle();
    rst = 0;
    #1 chk("rst_wait_ctrl", 32'(ctrl), 32'(NONE));
    tick();
    rst = 1;
    tick();
    chk("post_wait_ctrl", 32'(ctrl), 32'(NONE));
    mem_DM_read = 1; dm_ready = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("rewait_err_15", 32'(dm_err), 0);
    tick();
    chk("rewait_err_16", 32'(dm_err), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
